conv_line_buffer: RTL and testbench

//   Parametrised K-row line buffer feeding the conv-layer kernel array with full image rows.

---
 rtl/conv_line_buffer.sv | 217 +++++++++++++++++++++
 tb/tb_conv_line_buffer.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_line_buffer.sv
// conv_line_buffer
//   K-row circular line buffer between an image/feature-map source and the
//   conv kernel control FSM. Pixels stream in through a valid/ready handshake
//   in raster order. KERNEL_SIZE rows are held as a circular bank, and one
//   logical row (0 = oldest) is driven onto a wide bus with column 0 in the
//   MSBs. On row_advance the oldest bank is released and refilled with the
//   next image row.
// Ports
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   start_i           begin a new frame (aborts any frame in progress)
//   in_data_i         pixel word
//   in_valid_i        pixel word valid
//   in_ready_o        buffer accepts a word this cycle
//   row_sel_i         logical row select, >= KERNEL_SIZE reads all-zero
//   data_out_bus_o    selected row, column 0 in the MSBs
//   window_valid_o    KERNEL_SIZE consecutive rows resident and stable
//   row_advance_i     consumer finished with the current window
//   frame_done_o      one-cycle pulse at frame end
//   busy_o            not idle
module conv_line_buffer #(
    parameter int DATA_WIDTH   = 32,
    parameter int IMAGE_WIDTH  = 8,
    parameter int IMAGE_HEIGHT = 8,
    parameter int KERNEL_SIZE  = 3,
    localparam int SEL_W       = $clog2(KERNEL_SIZE + 1)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start_i,
    input  logic [DATA_WIDTH-1:0]             in_data_i,
    input  logic                              in_valid_i,
    output logic                              in_ready_o,
    input  logic [SEL_W-1:0]                  row_sel_i,
    output logic [IMAGE_WIDTH*DATA_WIDTH-1:0] data_out_bus_o,
    output logic                              window_valid_o,
    input  logic                              row_advance_i,
    output logic                              frame_done_o,
    output logic                              busy_o
);

    localparam int PTR_W = $clog2(KERNEL_SIZE);
    localparam int COL_W = $clog2(IMAGE_WIDTH);
    localparam int ROW_W = $clog2(IMAGE_HEIGHT + 1);
    localparam int SUM_W = SEL_W + 1;
    localparam int BUS_W = IMAGE_WIDTH * DATA_WIDTH;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(KERNEL_SIZE - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMAGE_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROWS_ALL = ROW_W'(IMAGE_HEIGHT);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_PRELOAD = 3'd1,
        S_READY   = 3'd2,
        S_LOAD    = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  base_ptr_q, base_ptr_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [ROW_W-1:0]  rows_in_q, rows_in_d;
    logic              in_ready_q, in_ready_d;
    logic              window_valid_q, window_valid_d;
    logic              frame_done_q, frame_done_d;
    logic              busy_q, busy_d;
    logic [DATA_WIDTH-1:0] bank_q [KERNEL_SIZE][IMAGE_WIDTH];

    logic              accept_s;
    logic [SUM_W-1:0]  sum_s;
    logic [SUM_W-1:0]  phys_s;

    // start wins over a same-cycle handshake, so that word is dropped
    assign accept_s = in_ready_q & in_valid_i & ~start_i;

    // Next-state, pointer and counter logic
    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        base_ptr_d = base_ptr_q;
        col_d      = col_q;
        rows_in_d  = rows_in_q;
        if (start_i) begin
            state_d    = S_PRELOAD;
            wr_ptr_d   = {PTR_W{1'b0}};
            base_ptr_d = {PTR_W{1'b0}};
            col_d      = {COL_W{1'b0}};
            rows_in_d  = {ROW_W{1'b0}};
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d = S_IDLE;
                end
                S_PRELOAD, S_LOAD: begin
                    if (accept_s && (col_q == COL_LAST)) begin
                        col_d     = {COL_W{1'b0}};
                        wr_ptr_d  = (wr_ptr_q == PTR_LAST) ? {PTR_W{1'b0}} : wr_ptr_q + 1'b1;
                        rows_in_d = rows_in_q + 1'b1;
                        // PRELOAD ends on the last row of the bank, LOAD after one row
                        if ((state_q == S_LOAD) || (wr_ptr_q == PTR_LAST)) begin
                            state_d = S_READY;
                        end else begin
                            state_d = state_q;
                        end
                    end else if (accept_s) begin
                        col_d = col_q + 1'b1;
                    end else begin
                        col_d = col_q;
                    end
                end
                S_READY: begin
                    if (row_advance_i && (rows_in_q == ROWS_ALL)) begin
                        state_d = S_DONE;
                    end else if (row_advance_i) begin
                        // Old oldest bank (== wr_ptr) becomes the refill target
                        state_d    = S_LOAD;
                        base_ptr_d = (base_ptr_q == PTR_LAST) ? {PTR_W{1'b0}} : base_ptr_q + 1'b1;
                    end else begin
                        state_d = S_READY;
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // Output flags decoded from the next state so they register cleanly
    always_comb begin
        in_ready_d     = (state_d == S_PRELOAD) || (state_d == S_LOAD);
        window_valid_d = (state_d == S_READY);
        frame_done_d   = (state_d == S_DONE);
        busy_d         = (state_d != S_IDLE);
    end

    // State, pointer, counter and output flag registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= S_IDLE;
            wr_ptr_q       <= {PTR_W{1'b0}};
            base_ptr_q     <= {PTR_W{1'b0}};
            col_q          <= {COL_W{1'b0}};
            rows_in_q      <= {ROW_W{1'b0}};
            in_ready_q     <= 1'b0;
            window_valid_q <= 1'b0;
            frame_done_q   <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            wr_ptr_q       <= wr_ptr_d;
            base_ptr_q     <= base_ptr_d;
            col_q          <= col_d;
            rows_in_q      <= rows_in_d;
            in_ready_q     <= in_ready_d;
            window_valid_q <= window_valid_d;
            frame_done_q   <= frame_done_d;
            busy_q         <= busy_d;
        end
    end

    // Row bank storage: cleared on reset/start, written on handshake
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int b = 0; b < KERNEL_SIZE; b++) begin
                for (int c = 0; c < IMAGE_WIDTH; c++) begin
                    bank_q[b][c] <= {DATA_WIDTH{1'b0}};
                end
            end
        end else if (start_i) begin
            for (int b = 0; b < KERNEL_SIZE; b++) begin
                for (int c = 0; c < IMAGE_WIDTH; c++) begin
                    bank_q[b][c] <= {DATA_WIDTH{1'b0}};
                end
            end
        end else begin
            for (int b = 0; b < KERNEL_SIZE; b++) begin
                for (int c = 0; c < IMAGE_WIDTH; c++) begin
                    if (accept_s && (wr_ptr_q == PTR_W'(b)) && (col_q == COL_W'(c))) begin
                        bank_q[b][c] <= in_data_i;
                    end
                end
            end
        end
    end

    // Logical-to-physical row mapping; sum < 2*KERNEL_SIZE so one subtract wraps it
    always_comb begin
        sum_s  = SUM_W'(base_ptr_q) + SUM_W'(row_sel_i);
        phys_s = (sum_s >= SUM_W'(KERNEL_SIZE)) ? (sum_s - SUM_W'(KERNEL_SIZE)) : sum_s;
    end

    // Read mux: selected bank onto the bus, column 0 in the MSBs
    always_comb begin
        data_out_bus_o = {BUS_W{1'b0}};
        if (row_sel_i < SEL_W'(KERNEL_SIZE)) begin
            for (int b = 0; b < KERNEL_SIZE; b++) begin
                if (phys_s == SUM_W'(b)) begin
                    for (int c = 0; c < IMAGE_WIDTH; c++) begin
                        data_out_bus_o[(IMAGE_WIDTH-1-c)*DATA_WIDTH +: DATA_WIDTH] = bank_q[b][c];
                    end
                end
            end
        end else begin
            data_out_bus_o = {BUS_W{1'b0}};
        end
    end

    assign in_ready_o     = in_ready_q;
    assign window_valid_o = window_valid_q;
    assign frame_done_o   = frame_done_q;
    assign busy_o         = busy_q;

endmodule

// File: tb/tb_conv_line_buffer.sv
// Directed testbench for conv_line_buffer (32-bit pixels, 8x8 image, 3-row kernel).
// Pixel value = row*16 + col; expected rows are built by the bench.
module tb_conv_line_buffer;

    localparam int DW    = 32;
    localparam int IW    = 8;
    localparam int IH    = 8;
    localparam int KS    = 3;
    localparam int SEL_W = $clog2(KS + 1);
    localparam int BUS_W = IW * DW;

    logic              clk;
    logic              rst;
    logic              start_i;
    logic [DW-1:0]     in_data_i;
    logic              in_valid_i;
    logic              in_ready_o;
    logic [SEL_W-1:0]  row_sel_i;
    logic [BUS_W-1:0]  data_out_bus_o;
    logic              window_valid_o;
    logic              row_advance_i;
    logic              frame_done_o;
    logic              busy_o;

    int checks_cnt;
    int errors_cnt;
    int windows_cnt;
    logic [BUS_W-1:0] exp_v;

    conv_line_buffer #(
        .DATA_WIDTH   (DW),
        .IMAGE_WIDTH  (IW),
        .IMAGE_HEIGHT (IH),
        .KERNEL_SIZE  (KS)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start_i        (start_i),
        .in_data_i      (in_data_i),
        .in_valid_i     (in_valid_i),
        .in_ready_o     (in_ready_o),
        .row_sel_i      (row_sel_i),
        .data_out_bus_o (data_out_bus_o),
        .window_valid_o (window_valid_o),
        .row_advance_i  (row_advance_i),
        .frame_done_o   (frame_done_o),
        .busy_o         (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare, count and report
    task automatic check_eq(input string tag, input logic [BUS_W-1:0] obs, input logic [BUS_W-1:0] exp);
        checks_cnt++;
        if (obs !== exp) begin
            errors_cnt++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [BUS_W-1:0] row_vec(input int r);
        logic [BUS_W-1:0] v;
        v = '0;
        for (int c = 0; c < IW; c++) v[(IW-1-c)*DW +: DW] = DW'(r * 16 + c);
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [DW-1:0] d, input int gap);
        logic rdy;
        logic done;
        repeat (gap) step();
        in_valid_i = 1'b1;
        in_data_i  = d;
        done = 1'b0;
        for (int n = 0; n < 40 && !done; n++) begin
            rdy = in_ready_o;
            step();
            if (rdy) done = 1'b1;
        end
        in_valid_i = 1'b0;
        if (!done) check_eq("handshake_timeout", BUS_W'(done), BUS_W'(1));
    endtask

    task automatic feed_row(input int r, input int first_col, input int last_col, input int maxgap);
        for (int c = first_col; c <= last_col; c++)
            send_word(DW'(r * 16 + c), (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
    endtask

    task automatic start_frame();
        start_i = 1'b1;
        step();
        start_i = 1'b0;
    endtask

    task automatic advance();
        row_advance_i = 1'b1;
        step();
        row_advance_i = 1'b0;
    endtask

    task automatic check_row(input string tag, input int sel, input logic [BUS_W-1:0] exp);
        row_sel_i = SEL_W'(sel);
        #1;
        check_eq(tag, data_out_bus_o, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        checks_cnt = 0; errors_cnt = 0; windows_cnt = 0;
        rst = 1'b1; start_i = 1'b0; in_data_i = '0; in_valid_i = 1'b0;
        row_sel_i = '0; row_advance_i = 1'b0;
        step(); step();
        // Reset state
        check_eq("rst_in_ready", BUS_W'(in_ready_o), BUS_W'(0));
        check_eq("rst_window_valid", BUS_W'(window_valid_o), BUS_W'(0));
        check_eq("rst_frame_done", BUS_W'(frame_done_o), BUS_W'(0));
        check_eq("rst_busy", BUS_W'(busy_o), BUS_W'(0));
        check_eq("rst_bus", data_out_bus_o, '0);
        rst = 1'b0;
        step();
        // row_advance in IDLE is ignored
        advance();
        check_eq("idle_adv_busy", BUS_W'(busy_o), BUS_W'(0));

        // Test 1: preload 24 words
        start_frame();
        check_eq("t1_in_ready", BUS_W'(in_ready_o), BUS_W'(1));
        check_eq("t1_busy", BUS_W'(busy_o), BUS_W'(1));
        feed_row(0, 0, IW-1, 0);
        feed_row(1, 0, IW-1, 0);
        feed_row(2, 0, IW-2, 0);
        check_eq("t1_wv_before_last", BUS_W'(window_valid_o), BUS_W'(0));
        feed_row(2, IW-1, IW-1, 0);
        check_eq("t1_wv_after_last", BUS_W'(window_valid_o), BUS_W'(1));
        check_eq("t1_ready_low", BUS_W'(in_ready_o), BUS_W'(0));
        check_row("t1_sel0", 0, row_vec(0));
        check_row("t1_sel1", 1, row_vec(1));
        check_row("t1_sel2", 2, row_vec(2));
        check_row("t1_sel3", 3, '0);

        // Test 2: advance and load row 3 into the old oldest bank
        advance();
        check_eq("t2_wv_load", BUS_W'(window_valid_o), BUS_W'(0));
        check_eq("t2_rdy_load", BUS_W'(in_ready_o), BUS_W'(1));
        feed_row(3, 0, 0, 0);
        exp_v = row_vec(0);
        exp_v[(IW-1)*DW +: DW] = 32'h0000_0030;
        check_row("t2_first_word_visible", 2, exp_v);
        feed_row(3, 1, IW-1, 0);
        check_eq("t2_wv_after", BUS_W'(window_valid_o), BUS_W'(1));
        check_row("t2_sel0", 0, row_vec(1));
        check_row("t2_sel1", 1, row_vec(2));
        check_row("t2_sel2", 2, row_vec(3));

        // Test 3: same as tests 1-2 with random valid gaps
        start_frame();
        for (int r = 0; r < KS; r++) feed_row(r, 0, IW-1, 3);
        check_eq("t3_wv", BUS_W'(window_valid_o), BUS_W'(1));
        check_eq("t3_ready_in_ready_state", BUS_W'(in_ready_o), BUS_W'(0));
        check_row("t3_pre_sel2", 2, row_vec(2));
        advance();
        feed_row(3, 0, IW-1, 3);
        check_eq("t3_ready_after_load", BUS_W'(in_ready_o), BUS_W'(0));
        check_row("t3_sel0", 0, row_vec(1));
        check_row("t3_sel1", 1, row_vec(2));
        check_row("t3_sel2", 2, row_vec(3));

        // Test 4: full frame, 6 windows
        start_frame();
        for (int r = 0; r < KS; r++) feed_row(r, 0, IW-1, 0);
        if (window_valid_o) windows_cnt++;
        for (int k = 1; k <= IH - KS; k++) begin
            advance();
            feed_row(k + KS - 1, 0, IW-1, 1);
            if (window_valid_o) windows_cnt++;
            check_row($sformatf("t4_w%0d_sel0", k), 0, row_vec(k));
            check_row($sformatf("t4_w%0d_sel2", k), 2, row_vec(k + 2));
        end
        check_eq("t4_windows", BUS_W'(windows_cnt), BUS_W'(IH - KS + 1));
        check_eq("t4_fd_before", BUS_W'(frame_done_o), BUS_W'(0));
        advance();
        check_eq("t4_frame_done", BUS_W'(frame_done_o), BUS_W'(1));
        check_eq("t4_wv_done", BUS_W'(window_valid_o), BUS_W'(0));
        step();
        check_eq("t4_frame_done_pulse", BUS_W'(frame_done_o), BUS_W'(0));
        check_eq("t4_busy_after", BUS_W'(busy_o), BUS_W'(0));

        // Test 5: start during LOAD at col 4, with a same-cycle word
        start_frame();
        for (int r = 0; r < KS; r++) feed_row(r, 0, IW-1, 0);
        advance();
        feed_row(3, 0, 3, 0);
        in_valid_i = 1'b1;
        in_data_i  = 32'hDEAD_BEEF;
        start_frame();
        in_valid_i = 1'b0;
        check_eq("t5_in_ready", BUS_W'(in_ready_o), BUS_W'(1));
        check_eq("t5_wv", BUS_W'(window_valid_o), BUS_W'(0));
        check_eq("t5_no_done", BUS_W'(frame_done_o), BUS_W'(0));
        check_row("t5_zero0", 0, '0);
        check_row("t5_zero1", 1, '0);
        check_row("t5_zero2", 2, '0);
        check_row("t5_zero3", 3, '0);
        for (int r = 0; r < KS; r++) feed_row(r, 0, IW-1, 0);
        check_eq("t5_wv_after", BUS_W'(window_valid_o), BUS_W'(1));
        check_row("t5_sel0", 0, row_vec(0));
        check_row("t5_sel2", 2, row_vec(2));

        // Test 6: async reset mid-LOAD
        advance();
        feed_row(3, 0, 2, 0);
        rst = 1'b1;
        row_sel_i = SEL_W'(1);
        #1;
        check_eq("t6_in_ready", BUS_W'(in_ready_o), BUS_W'(0));
        check_eq("t6_wv", BUS_W'(window_valid_o), BUS_W'(0));
        check_eq("t6_busy", BUS_W'(busy_o), BUS_W'(0));
        check_eq("t6_fd", BUS_W'(frame_done_o), BUS_W'(0));
        check_eq("t6_bus", data_out_bus_o, '0);
        step();
        rst = 1'b0;
        step();
        start_frame();
        for (int r = 0; r < KS; r++) feed_row(r, 0, IW-1, 0);
        check_eq("t6_wv_after", BUS_W'(window_valid_o), BUS_W'(1));
        check_row("t6_sel1", 1, row_vec(1));

        $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
